conv_kxk_stream: RTL

Parametrised streaming 2-D convolution engine: a generalised successor to the fixed 3x3 `conv_top`. Accepts a K×K signed weight kernel serially into a shadow bank, then a raster-ordered square image (runtime `image_size`). It keeps K-1 line buffers and a K×K sliding window, and emits one bias-subtracted, shifted, saturated result per fully populated window (valid convolution, no padding). It sits between the pixel source and the feature-map sink in the CNN datapath.

---
 rtl/conv_kxk_stream.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_kxk_stream.sv
// rtl/conv_kxk_stream.sv - streaming KxK valid convolution with shadow weight bank; CONV_RELU_EN clamps negative results
module conv_kxk_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int MAX_W  = 256,
  parameter int ACC_W  = 2*DATA_W+6
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [8:0]        image_size,
  input  logic              pi_weight_valid,
  input  logic [DATA_W-1:0] pi_weight,
  input  logic              pi_data_valid,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [15:0]       bias,
  input  logic [4:0]        shift,
  output logic [DATA_W-1:0] map_out,
  output logic              map_out_valid,
  output logic              weight_pending
);

  localparam int KK     = K*K;
  localparam int WIDX_W = $clog2(KK);
  localparam int LB_AW  = $clog2(MAX_W);
  localparam int PROD_W = 2*DATA_W;
  localparam int DIFF_W = ACC_W+1;

  localparam logic [8:0] K_M1  = 9'(K-1);
  localparam logic [9:0] K_N   = 10'(K);
  localparam logic [9:0] MAX_N = 10'(MAX_W);

  localparam logic signed [DIFF_W-1:0] SAT_MAX =
    {{(DIFF_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] SAT_MIN =
    {{(DIFF_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;
  logic [8:0] n_q, n_d, col_q, col_d, row_q, row_d;
  logic [8:0] cur_n, cur_col, cur_row;
  logic       frame_ok, win_ok, commit;

  logic signed [DATA_W-1:0] w_sh_q  [KK];
  logic signed [DATA_W-1:0] w_act_q [KK];
  logic [WIDX_W-1:0]        widx_q;
  logic                     pending_q;

  logic signed [DATA_W-1:0] lb_q  [K-1][MAX_W];
  logic signed [DATA_W-1:0] win_q [K][K];
  logic signed [DATA_W-1:0] col_vec [K];
  logic [LB_AW-1:0]         lb_addr;
  logic                     win_vld_q;

  logic signed [PROD_W-1:0] prod_q [KK];
  logic                     s1_vld_q;
  logic signed [ACC_W-1:0]  sum, acc_q;
  logic                     s2_vld_q;
  logic signed [DIFF_W-1:0] diff, shifted;
  logic [DATA_W-1:0]        res;
  logic [DATA_W-1:0]        map_out_q;
  logic                     map_out_valid_q;

  // Kernel only swaps while no frame is running, so the active bank is stable for a whole frame.
  assign commit = pending_q && (state_q == IDLE);

  // Shadow fill, completion flag and shadow-to-active commit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < KK; i++) begin
        w_sh_q[i]  <= '0;
        w_act_q[i] <= '0;
      end
      widx_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < KK; i++) w_act_q[i] <= w_sh_q[i];
      end
      if (pi_weight_valid) begin
        if (pending_q) begin
          // A fresh weight after a complete kernel restarts the fill.
          w_sh_q[0] <= pi_weight;
          widx_q    <= WIDX_W'(1);
          pending_q <= 1'b0;
        end else begin
          w_sh_q[widx_q] <= pi_weight;
          if (widx_q == WIDX_W'(KK-1)) begin
            widx_q    <= '0;
            pending_q <= 1'b1;
          end else begin
            widx_q <= widx_q + WIDX_W'(1);
          end
        end
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Frame next-state: in IDLE the first pixel sees N=image_size and position (0,0).
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    col_d   = col_q;
    row_d   = row_q;
    cur_n   = n_q;
    cur_col = col_q;
    cur_row = row_q;
    if (state_q == IDLE) begin
      cur_n   = image_size;
      cur_col = '0;
      cur_row = '0;
    end
    if (pi_data_valid) begin
      state_d = RUN;
      n_d     = cur_n;
      if (cur_col == cur_n - 9'd1) begin
        col_d = '0;
        if (cur_row == cur_n - 9'd1) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = cur_row + 9'd1;
        end
      end else begin
        col_d = cur_col + 9'd1;
      end
    end
  end

  assign frame_ok = ({1'b0, cur_n} >= K_N) && ({1'b0, cur_n} <= MAX_N);
  assign win_ok   = frame_ok && (cur_row >= K_M1) && (cur_col >= K_M1);
  // Out-of-range frames never produce results, so their line-buffer address is parked at 0.
  assign lb_addr  = frame_ok ? cur_col[LB_AW-1:0] : '0;

  // New window column: oldest row from the deepest line buffer, newest row is the incoming pixel.
  always_comb begin
    for (int r = 0; r < K-1; r++) col_vec[r] = lb_q[K-2-r][lb_addr];
    col_vec[K-1] = pi_data;
  end

  // Line buffers and sliding window advance only on consumed pixels.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < K-1; i++)
        for (int a = 0; a < MAX_W; a++) lb_q[i][a] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      win_vld_q <= 1'b0;
    end else begin
      win_vld_q <= pi_data_valid && win_ok;
      if (pi_data_valid) begin
        if (frame_ok) begin
          lb_q[0][lb_addr] <= pi_data;
          for (int i = 1; i < K-1; i++) lb_q[i][lb_addr] <= lb_q[i-1][lb_addr];
        end
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-1] <= col_vec[r];
        end
      end
    end
  end

  // S1: one signed product per kernel tap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < KK; i++) prod_q[i] <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_q[r*K+c] <= PROD_W'(win_q[r][c]) * PROD_W'(w_act_q[r*K+c]);
      s1_vld_q <= win_vld_q;
    end
  end

  // S2 sum of all taps in accumulator width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < KK; i++) sum = sum + ACC_W'(prod_q[i]);
  end

  // S2 register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q    <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      acc_q    <= sum;
      s2_vld_q <= s1_vld_q;
    end
  end

  // S3 bias subtraction, arithmetic shift and saturation (one extra bit keeps the subtraction exact).
  always_comb begin
    diff    = DIFF_W'(acc_q) - DIFF_W'($signed(bias));
    shifted = diff >>> shift;
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                        res = shifted[DATA_W-1:0];
`ifdef CONV_RELU_EN
    if (res[DATA_W-1]) res = '0;
`else
`endif
  end

  // S3 output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      map_out_q       <= '0;
      map_out_valid_q <= 1'b0;
    end else begin
      map_out_q       <= res;
      map_out_valid_q <= s2_vld_q;
    end
  end

  assign map_out        = map_out_q;
  assign map_out_valid  = map_out_valid_q;
  assign weight_pending = pending_q;

endmodule
